// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that drives the select lines of one
// shared 4-to-1 mux on behalf of four level-requesting clients.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   level requests, req[k] routes mux input k
//   gnt[3:0]   registered one-hot grant, zero when idle
//   s1, s0     registered mux select, stable for the whole busy window
//   busy       a grant is active (equals |gnt)
//   owner[1:0] index of the current or most recent grantee
//
// Build option: define MUX4_ARB_PREEMPT_EN to build the hold counter that
// forces a release after MAX_HOLD granted cycles when others are waiting.
// Without it the owner keeps the grant until its own request drops.

module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       busy,
    output logic [1:0] owner
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    if (MAX_HOLD < 2 || MAX_HOLD > 15 || (1 << HOLD_W) <= MAX_HOLD) begin : g_cfg_chk
        $error("mux4_rr_arbiter: illegal MAX_HOLD/HOLD_W");
    end

    logic [0:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;

    logic       pick_vld;
    logic [1:0] pick;
    logic       force_rel;

    // First asserted request in rotated order starting at ptr.
    always_comb begin
        logic [1:0] idx;
        pick_vld = 1'b0;
        pick     = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

`ifdef MUX4_ARB_PREEMPT_EN
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              others;

    assign others    = |(req & ~gnt_q);
    assign force_rel = (cnt_q == HOLD_W'(MAX_HOLD - 1)) && others;
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef MUX4_ARB_PREEMPT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_BUSY;
                    gnt_d   = 4'b0001 << pick;
                    sel_d   = pick;
                    ptr_d   = pick + 2'd1;
`ifdef MUX4_ARB_PREEMPT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUSY: begin
                // Release always passes through IDLE for one cycle, so the
                // select lines can only move while busy is low.
                if (!req[sel_q] || force_rel) begin
                    state_d = S_IDLE;
                    gnt_d   = 4'b0000;
                end
`ifdef MUX4_ARB_PREEMPT_EN
                else if (cnt_q != HOLD_W'(MAX_HOLD - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
`ifdef MUX4_ARB_PREEMPT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef MUX4_ARB_PREEMPT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign owner = sel_q;
    assign busy  = (state_q == S_BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: randomized and directed checks of mux4_rr_arbiter
// against a behavioural model of the round-robin grant rules.

module tb_mux4_rr_arbiter;

    localparam int MAXH = 8;
`ifdef MUX4_ARB_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       s1, s0, busy;
    logic [1:0] owner;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner index or -1, last grantee, scan start, cycles held.
    int m_own, m_last, m_ptr, m_held;

    mux4_rr_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .s1(s1), .s0(s0), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_own = -1; m_last = 0; m_ptr = 0; m_held = 0;
    endfunction

    function automatic void model_step(input logic [3:0] r);
        int k;
        if (m_own < 0) begin
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (m_own < 0 && r[k]) begin
                    m_own = k; m_last = k;
                    m_ptr = (k + 1) % 4; m_held = 1;
                end
            end
        end else if (!r[m_own]) begin
            m_own = -1;
        end else if (PRE && m_held >= MAXH &&
                     (r & ~(4'b0001 << m_own)) != 4'b0000) begin
            m_own = -1;
        end else begin
            m_held++;
        end
    endfunction

    function automatic logic [8:0] model_vec();
        logic [3:0] g;
        g = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
        return {g, (m_own >= 0), 2'(m_last), 2'(m_last)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {gnt, busy, s1, s0, owner};
    endfunction

    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== 9'h000) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 9'h000);
        end
        rst_n = 1'b1;
        cycle(4'b1111);
        n_cmp++;
        if ({gnt, s1, s0, busy} !== 7'b0001_00_1) begin
            n_bad++;
            $display("FAIL reset_first_grant: got %b want %b",
                     {gnt, s1, s0, busy}, 7'b0001_00_1);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0100);
            n_cmp++;
            if (dut_vec() !== model_vec() || {gnt, s1, s0} !== 6'b0100_10) begin
                n_bad++;
                $display("FAIL single_hold[%0d]: got %h want %h",
                         i, dut_vec(), model_vec());
            end
        end
        cycle(4'b0000);
        n_cmp++;
        if ({gnt, busy, s1, s0, owner} !== 9'b0000_0_10_10) begin
            n_bad++;
            $display("FAIL single_release: got %b want %b",
                     dut_vec(), 9'b0000_0_10_10);
        end
    endtask

    task automatic test_all_rr();
        int q[$];
        logic [3:0] pg;
        int bad;
        do_reset();
        pg = 4'b0000;
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            cycle(4'b1111);
            if (dut_vec() !== model_vec()) bad++;
            if (gnt != 4'b0000 && pg == 4'b0000) q.push_back(int'(owner));
            pg = gnt;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL all_rr_model: %0d cycles differ, want 0", bad);
        end
        if (PRE) begin
            n_cmp++;
            if (q.size() < 5 || q[0] != 0 || q[1] != 1 || q[2] != 2 ||
                q[3] != 3 || q[4] != 0) begin
                n_bad++;
                $display("FAIL all_rr_order: got %p want 0 1 2 3 0", q);
            end
        end else begin
            n_cmp++;
            if (q.size() != 1 || gnt !== 4'b0001) begin
                n_bad++;
                $display("FAIL all_rr_keep: got %p gnt %b want one grant 0001",
                         q, gnt);
            end
            cycle(4'b1110);
            cycle(4'b1110);
            n_cmp++;
            if (gnt !== 4'b0010 || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL all_rr_next: got %b want 0010", gnt);
            end
        end
    endtask

    task automatic test_hold_retain();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1000);
            n_cmp++;
            if (gnt !== 4'b1000 || dut_vec() !== model_vec()) begin
                n_bad++;
                $display("FAIL hold_retain[%0d]: got %b want 1000", i, gnt);
            end
        end
        cycle(4'b1010);
        n_cmp++;
        if (gnt !== (PRE ? 4'b0000 : 4'b1000)) begin
            n_bad++;
            $display("FAIL hold_preempt: got %b want %b",
                     gnt, PRE ? 4'b0000 : 4'b1000);
        end
        cycle(4'b1010);
        n_cmp++;
        if (gnt !== (PRE ? 4'b0010 : 4'b1000) || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL hold_next: got %b want %b",
                     gnt, PRE ? 4'b0010 : 4'b1000);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(4'b0010);
        n_cmp++;
        if ({gnt, s1, s0} !== 6'b0010_01) begin
            n_bad++;
            $display("FAIL areset_pre: got %b want 001001", {gnt, s1, s0});
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({gnt, busy, s1, s0, owner} !== 9'h000) begin
            n_bad++;
            $display("FAIL areset_drop: got %b want 0", dut_vec());
        end
        #1;
        rst_n = 1'b1;
        cycle(4'b1010);
        n_cmp++;
        if (gnt !== 4'b0010 || dut_vec() !== model_vec()) begin
            n_bad++;
            $display("FAIL areset_restart: got %b want 0010", gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       pb;
        logic [1:0] ps;
        int bad_m, bad_i;
        do_reset();
        r = 4'b0000;
        pb = 1'b0;
        ps = 2'd0;
        bad_m = 0;
        bad_i = 0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            cycle(r);
            if (dut_vec() !== model_vec()) begin
                bad_m++;
                if (bad_m < 4)
                    $display("FAIL rand_model @%0d: got %h want %h",
                             i, dut_vec(), model_vec());
            end
            if (!$onehot0(gnt) || busy !== (|gnt) ||
                (pb && busy && {s1, s0} !== ps))
                bad_i++;
            pb = busy;
            ps = {s1, s0};
        end
        n_cmp++;
        if (bad_m != 0) begin
            n_bad++;
            $display("FAIL rand_model_total: %0d cycles differ, want 0", bad_m);
        end
        n_cmp++;
        if (bad_i != 0) begin
            n_bad++;
            $display("FAIL rand_invariants: %0d violations, want 0", bad_i);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_rr();
        test_hold_retain();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and select controller that shares one 4-to-1 multiplexer among four requesters.
- Each requester raises a level request. The block grants exactly one requester at a time and drives the mux select lines s1/s0 to route that requester's input to Y.
- It sits directly in front of the mux select inputs. Downstream logic treats Y as valid while busy=1.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles before forced release when other requests are pending; legal range 2..15.
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  level requests; req[k] is requester k (mux input ik).
- gnt  output  4  one-hot registered grant; all zero when idle.
- s1  output  1  mux select MSB, registered.
- s0  output  1  mux select LSB, registered.
- busy  output  1  a grant is active; Y reflects the granted input.
- owner  output  2  index of current/last granted requester.

Behaviour:
- Reset (rst_n=0, asynchronous): gnt=4'b0000, s1=0, s0=0, busy=0, owner=0, state=IDLE, priority pointer ptr=0, hold counter=0.
- Reset asserted mid-grant drops gnt/busy immediately, without waiting for a clock edge. After release, arbitration restarts from ptr=0.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE; outputs hold gnt=0, busy=0, and s1/s0 keep their last value.
  - Otherwise pick the first asserted req[k] scanning k=ptr, ptr+1, ... mod 4.
  - Next edge: gnt[k]=1, {s1,s0}=k, owner=k, busy=1, counter=0, ptr=(k+1) mod 4, go to BUSY.
  - Latency from a req rising edge (sampled) to gnt is 1 cycle.
- BUSY, owner k:
  - If req[k]=0 at an edge, release on that edge: gnt=0, busy=0, go to IDLE. s1/s0 and owner hold their values.
  - Else if counter==MAX_HOLD-1 and any other req bit is set, forced release with the same outputs as a normal release.
  - Else stay in BUSY; counter increments, saturating at MAX_HOLD-1.
- Every release spends exactly one cycle in IDLE, so the minimum gap between two grants is 1 cycle. This guarantees that s1/s0 never change while busy=1.
- s1/s0 change only on the edge that issues a new grant. They are stable for the entire busy window.
- gnt is always one-hot or zero. busy == |gnt at all times.
- ptr wrap-around: a grant to 3 sets ptr=0.
- Simultaneous requests resolve strictly by the rotated scan order. A requester that drops req in the same cycle it would be chosen is not granted.
- A req that deasserts and reasserts while another requester is owner waits its turn; no request state is stored.
- Starvation bound: with the preemption feature, any persistently asserted req is granted within 3*(MAX_HOLD+1)+1 cycles.

Optional Feature:
- Macro: MUX4_ARB_PREEMPT_EN.
- Defined: hold counter and MAX_HOLD forced release are implemented as described above.
- Undefined: no counter is built and MAX_HOLD/HOLD_W are unused. The owner keeps the grant until its own req drops, and all other Behaviour rules are unchanged.

Test Plan:
- Reset with req=4'b1111 held: gnt=0, busy=0, {s1,s0}=00. Release rst_n: one cycle later gnt=0001, {s1,s0}=00, busy=1.
- req=4'b0100 only, held 3 cycles then dropped: gnt=0100 and {s1,s0}=10 for 3 cycles, then gnt=0 on the edge after req drops. s1/s0 stay 10; owner=2.
- req=4'b1111 held continuously, MUX4_ARB_PREEMPT_EN defined, MAX_HOLD=8: grant sequence 0,1,2,3,0. Each grant lasts 8 cycles with a 1-cycle idle gap between grants; {s1,s0} follow 00,01,10,11,00.
- Same stimulus with the macro undefined: gnt=0001 held indefinitely. Drop req[0]: next grant is requester 1.
- Requester 3 owner with req=4'b1000, counter at 7, no other requests: grant is retained. Then assert req[1] at cycle 10 of the hold: release on the next edge, idle 1 cycle, then gnt=0010.
- Assert rst_n=0 mid-cycle during gnt=0010: gnt, busy and s1/s0 go to 0 before the next clk edge. After reset, req=4'b1010 grants requester 1 first (ptr=0).
